ins_decode_hazard: RTL and testbench
====================================

INS_DECODE_HAZARD -- requirements
Module: ins_decode_hazard

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 ins  input  24  instruction from program counter/instruction memory stage.
REQ-005 Current_Address  input  8  address of ins.
REQ-006 jmp_loc  output  8  jump target to PC stage.
REQ-007 pc_mux_sel  output  1  1 = PC loads jmp_loc; 0 = PC increments.
REQ-008 Stall  output  1  1 = PC holds.
REQ-009 Stall_pm  output  1  1 = instruction memory output holds.
REQ-010 op_ex, rd_ex, rs1_ex, rs2_ex  output  5/3/3/3  ID/EX opcode and register fields.
REQ-011 imm_ex, pc_ex  output  8/8  ID/EX immediate and instruction address.
REQ-012 valid_ex, reg_wr_ex, mem_rd_ex, mem_wr_ex  output  1 each  ID/EX valid and control bits.
REQ-013 stall_cnt, flush_cnt  output  8 each  saturating performance counters.

Function
REQ-014 Instruction format SHALL be: op=ins[23:19], rd=ins[18:16], rs1=ins[15:13], rs2=ins[12:10], imm=ins[7:0].
REQ-015 Opcodes SHALL be: 00000 NOP; 10000 LOAD (reg_wr, mem_rd, reads rs1); 10001 STORE (mem_wr, reads rs1, rs2); 11000 JMP (no reads, no writes); all others ALU (reg_wr, reads rs1, rs2).
REQ-016 The IF/ID register (ins_id, pc_id, valid_id) SHALL capture ins and Current_Address on each clk edge unless Stall=1; valid_id SHALL capture 1 unless a flush is in progress.
REQ-017 Load-use hazard SHALL be asserted combinationally when valid_id=1, valid_ex=1, mem_rd_ex=1, and rd_ex equals an rs field the ID instruction reads.
REQ-018 On a hazard: Stall=Stall_pm=1 in the same cycle; IF/ID holds; ID/EX loads a bubble (valid_ex=0, all control bits 0, fields 0) at the next edge.
REQ-019 Hazard stall SHALL last exactly one cycle per LOAD because the bubble clears the condition.
REQ-020 On valid_id=1 and op=JMP with no hazard: pc_mux_sel=1 and jmp_loc=imm_id combinationally in the same cycle; otherwise pc_mux_sel=0 and jmp_loc=0.
REQ-021 A JMP SHALL enter ID/EX as a valid instruction with reg_wr, mem_rd and mem_wr all 0.
REQ-022 The FSM SHALL have states RUN, STALL and FLUSH.
REQ-023 FSM transitions SHALL be:
- RUN->STALL on hazard.
- RUN->FLUSH on jump.
- STALL->RUN, or STALL->FLUSH if the held instruction is JMP.
- FLUSH->RUN unconditionally.
REQ-024 In FLUSH, the IF/ID load SHALL write valid_id=0, discarding the instruction fetched in the jump cycle, so exactly one slot is squashed per JMP.
REQ-025 A JMP in FLUSH state cannot occur, because valid_id=0 in that state.
REQ-026 If hazard and JMP decode coincide, hazard SHALL take priority.
REQ-027 That coincidence cannot arise, since JMP reads no registers.
REQ-028 Otherwise ID/EX SHALL load the decoded IF/ID contents every edge.
REQ-029 stall_cnt SHALL increment once per hazard cycle; flush_cnt SHALL increment once per squashed slot; both SHALL saturate at 255 and never wrap.
REQ-030 Register index 0 SHALL receive no special treatment, so hazards on rd=0 are detected.

Reset
REQ-031 On reset=1, regardless of clk: valid_id=0, ins_id=0, pc_id=0, all ID/EX outputs 0, FSM=RUN, stall_cnt=flush_cnt=0.
REQ-032 While reset=1: Stall=Stall_pm=pc_mux_sel=0 and jmp_loc=0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL abort the operation; the first post-reset instruction SHALL be captured as valid.

Verification
REQ-034 Reset, then ALU 01000/rd=2 at addr 0 -> after two edges valid_ex=1, op_ex=01000, rd_ex=2, reg_wr_ex=1, pc_ex=0, Stall=0.
REQ-035 LOAD rd=3, then ALU rs1=3 -> exactly one cycle Stall=Stall_pm=1, one bubble (valid_ex=0), ALU then in ID/EX, stall_cnt=1.
REQ-036 LOAD rd=3, then ALU rs1=4, rs2=5 -> no Stall, stall_cnt=0.
REQ-037 JMP imm=8 at addr 5 -> pc_mux_sel=1, jmp_loc=8 for one cycle; instruction at addr 6 squashed (valid_id=0); next valid pc_ex=8; flush_cnt=1.
REQ-038 256 consecutive LOAD/use pairs -> stall_cnt=255, no wrap.
REQ-039 reset=1 pulsed asynchronously during STALL -> all outputs 0 immediately; next instruction proceeds with no stall.

Source files
------------

// File: rtl/ins_decode_hazard_if.sv
// ins_decode_hazard_if: PC/fetch-side and ID/EX-side signals of the decode stage
interface ins_decode_hazard_if;
    logic [23:0] ins;
    logic [7:0]  Current_Address;
    logic [7:0]  jmp_loc;
    logic        pc_mux_sel;
    logic        Stall;
    logic        Stall_pm;
    logic [4:0]  op_ex;
    logic [2:0]  rd_ex;
    logic [2:0]  rs1_ex;
    logic [2:0]  rs2_ex;
    logic [7:0]  imm_ex;
    logic [7:0]  pc_ex;
    logic        valid_ex;
    logic        reg_wr_ex;
    logic        mem_rd_ex;
    logic        mem_wr_ex;
    logic [7:0]  stall_cnt;
    logic [7:0]  flush_cnt;

    modport master (
        output ins, Current_Address,
        input  jmp_loc, pc_mux_sel, Stall, Stall_pm, op_ex, rd_ex, rs1_ex, rs2_ex,
               imm_ex, pc_ex, valid_ex, reg_wr_ex, mem_rd_ex, mem_wr_ex, stall_cnt, flush_cnt
    );

    modport slave (
        input  ins, Current_Address,
        output jmp_loc, pc_mux_sel, Stall, Stall_pm, op_ex, rd_ex, rs1_ex, rs2_ex,
               imm_ex, pc_ex, valid_ex, reg_wr_ex, mem_rd_ex, mem_wr_ex, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ins_decode_hazard.sv
// ins_decode_hazard: IF/ID + ID/EX registers with load-use stall and one-slot jump flush
module ins_decode_hazard (
    input logic              clk,
    input logic              reset,
    ins_decode_hazard_if.slave bus
);
    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_LOAD  = 5'b10000;
    localparam logic [4:0] OP_STORE = 5'b10001;
    localparam logic [4:0] OP_JMP   = 5'b11000;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [23:0] ins_id;
    logic [7:0]  pc_id;
    logic        valid_id;
    logic [4:0]  op_id;
    logic [2:0]  rd_id, rs1_id, rs2_id;
    logic [7:0]  imm_id;
    logic        rd_rs1, rd_rs2, is_load, is_store, is_jmp, hazard, jump, unused_bits;
    logic [4:0]  op_ex;
    logic [2:0]  rd_ex, rs1_ex, rs2_ex;
    logic [7:0]  imm_ex, pc_ex, stall_cnt, flush_cnt;
    logic        valid_ex, reg_wr_ex, mem_rd_ex, mem_wr_ex;

    assign op_id       = ins_id[23:19];
    assign rd_id       = ins_id[18:16];
    assign rs1_id      = ins_id[15:13];
    assign rs2_id      = ins_id[12:10];
    assign imm_id      = ins_id[7:0];
    assign unused_bits = ^ins_id[9:8];

    assign is_load  = op_id == OP_LOAD;
    assign is_store = op_id == OP_STORE;
    assign is_jmp   = op_id == OP_JMP;
    assign rd_rs1   = !(op_id == OP_NOP || is_jmp);
    assign rd_rs2   = rd_rs1 && !is_load;
    // rd=0 is compared like any other register
    assign hazard = valid_id && valid_ex && mem_rd_ex &&
                    ((rd_rs1 && rd_ex == rs1_id) || (rd_rs2 && rd_ex == rs2_id));
    assign jump   = valid_id && is_jmp && !hazard;

    always_comb begin
        state_nxt = RUN;
        state_nxt = (state == FLUSH) ? RUN :
                    (state == RUN && hazard) ? STALL :
                    jump ? FLUSH : RUN;
    end

    always_ff @(posedge clk or posedge reset) state <= reset ? RUN : state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ins_id    <= '0;
            pc_id     <= '0;
            valid_id  <= 1'b0;
            op_ex     <= '0;
            rd_ex     <= '0;
            rs1_ex    <= '0;
            rs2_ex    <= '0;
            imm_ex    <= '0;
            pc_ex     <= '0;
            valid_ex  <= 1'b0;
            reg_wr_ex <= 1'b0;
            mem_rd_ex <= 1'b0;
            mem_wr_ex <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (hazard) begin
            op_ex     <= '0;
            rd_ex     <= '0;
            rs1_ex    <= '0;
            rs2_ex    <= '0;
            imm_ex    <= '0;
            pc_ex     <= '0;
            valid_ex  <= 1'b0;
            reg_wr_ex <= 1'b0;
            mem_rd_ex <= 1'b0;
            mem_wr_ex <= 1'b0;
            stall_cnt <= stall_cnt + {7'd0, stall_cnt != 8'hff};
        end else begin
            // the slot fetched alongside a taken jump is captured as invalid
            ins_id    <= bus.ins;
            pc_id     <= bus.Current_Address;
            valid_id  <= state_nxt != FLUSH;
            op_ex     <= op_id;
            rd_ex     <= rd_id;
            rs1_ex    <= rs1_id;
            rs2_ex    <= rs2_id;
            imm_ex    <= imm_id;
            pc_ex     <= pc_id;
            valid_ex  <= valid_id;
            reg_wr_ex <= valid_id && (is_load || (rd_rs2 && !is_store));
            mem_rd_ex <= valid_id && is_load;
            mem_wr_ex <= valid_id && is_store;
            flush_cnt <= flush_cnt + {7'd0, state_nxt == FLUSH && flush_cnt != 8'hff};
        end
    end

    assign bus.Stall      = hazard;
    assign bus.Stall_pm   = hazard;
    assign bus.pc_mux_sel = jump;
    assign bus.jmp_loc    = jump ? imm_id : 8'd0;
    assign bus.op_ex      = op_ex;
    assign bus.rd_ex      = rd_ex;
    assign bus.rs1_ex     = rs1_ex;
    assign bus.rs2_ex     = rs2_ex;
    assign bus.imm_ex     = imm_ex;
    assign bus.pc_ex      = pc_ex;
    assign bus.valid_ex   = valid_ex;
    assign bus.reg_wr_ex  = reg_wr_ex;
    assign bus.mem_rd_ex  = mem_rd_ex;
    assign bus.mem_wr_ex  = mem_wr_ex;
    assign bus.stall_cnt  = stall_cnt;
    assign bus.flush_cnt  = flush_cnt;
endmodule

// File: tb/tb_ins_decode_hazard.sv
// tb_ins_decode_hazard: directed + random programs checked against a slot-level pipeline model
module tb_ins_decode_hazard;
    localparam logic [4:0] LD = 5'b10000, ST = 5'b10001, JP = 5'b11000, AL = 5'b01000;

    typedef struct packed {
        logic v; logic [4:0] op; logic [2:0] rd, rs1, rs2; logic [7:0] imm, pc;
        logic rw, mr, mw;
    } ex_t;

    logic clk = 1'b0, rst = 1'b1;
    int   checks = 0, failures = 0, stall_seen = 0;
    logic [23:0] prog [256];
    logic [23:0] m_ins;
    logic [7:0]  m_pc, m_pc_id;
    logic        m_vid;
    ex_t         m_ex;
    int          m_sc, m_fc;

    ins_decode_hazard_if bus ();
    ins_decode_hazard dut (.clk(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk(logic [4:0] op, logic [2:0] rd, logic [2:0] s1, logic [2:0] s2, logic [7:0] imm);
        return {op, rd, s1, s2, 2'b00, imm};
    endfunction

    function automatic logic is_alu(logic [4:0] op);
        return !(op == 5'd0 || op == LD || op == ST || op == JP);
    endfunction

    function automatic ex_t decode(logic [23:0] i, logic [7:0] p, logic v);
        ex_t e;
        e.v = v; e.op = i[23:19]; e.rd = i[18:16]; e.rs1 = i[15:13]; e.rs2 = i[12:10];
        e.imm = i[7:0]; e.pc = p;
        e.mr = v && e.op == LD;
        e.mw = v && e.op == ST;
        e.rw = v && (e.op == LD || is_alu(e.op));
        return e;
    endfunction

    function automatic logic model_hz();
        logic [4:0] op = m_ins[23:19];
        logic r1 = op == LD || op == ST || is_alu(op);
        logic r2 = op == ST || is_alu(op);
        return m_vid && m_ex.v && m_ex.mr &&
               ((r1 && m_ex.rd == m_ins[15:13]) || (r2 && m_ex.rd == m_ins[12:10]));
    endfunction

    function automatic logic [33:0] dut_ex();
        return {bus.valid_ex, bus.op_ex, bus.rd_ex, bus.rs1_ex, bus.rs2_ex, bus.imm_ex,
                bus.pc_ex, bus.reg_wr_ex, bus.mem_rd_ex, bus.mem_wr_ex};
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_stall"}, {bus.Stall, bus.Stall_pm}, 2'b00);
        check({tag, "_jump"}, {bus.pc_mux_sel, bus.jmp_loc}, 9'd0);
        check({tag, "_ex"}, dut_ex(), 34'd0);
        check({tag, "_cnt"}, {bus.stall_cnt, bus.flush_cnt}, 16'd0);
    endtask

    // leaves the bench at posedge+1 with reset released and the model at its reset state
    task automatic do_reset();
        rst = 1'b1;
        m_ins = '0; m_pc_id = '0; m_vid = 1'b0; m_ex = '0; m_sc = 0; m_fc = 0; m_pc = '0;
        bus.ins = prog[0]; bus.Current_Address = 8'd0;
        #2 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cycle();
        logic hz, jp;
        ex_t  nex;
        @(negedge clk);
        hz = model_hz();
        jp = m_vid && m_ins[23:19] == JP && !hz;
        if (bus.Stall) stall_seen++;
        check("Stall", bus.Stall, hz);
        check("Stall_pm", bus.Stall_pm, hz);
        check("pc_mux_sel", bus.pc_mux_sel, jp);
        check("jmp_loc", bus.jmp_loc, jp ? m_ins[7:0] : 8'd0);
        check("id_ex", dut_ex(), m_ex);
        check("stall_cnt", bus.stall_cnt, m_sc);
        check("flush_cnt", bus.flush_cnt, m_fc);
        nex = hz ? ex_t'('0) : decode(m_ins, m_pc_id, m_vid);
        if (hz && m_sc < 255) m_sc++;
        if (jp && m_fc < 255) m_fc++;
        if (!hz) begin
            logic [7:0] tgt = m_ins[7:0];
            m_ins = prog[m_pc]; m_pc_id = m_pc; m_vid = !jp;
            m_pc = jp ? tgt : m_pc + 8'd1;
        end
        @(posedge clk);
        #1;
        m_ex = nex;
        bus.ins = prog[m_pc];
        bus.Current_Address = m_pc;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 256; i++) prog[i] = '0;
    endtask

    initial begin
        bus.ins = '0; bus.Current_Address = '0;
        // basic ALU flow
        fill_nop();
        prog[0] = mk(AL, 3'd2, 3'd1, 3'd1, 8'h11);
        do_reset();
        repeat (2) cycle();
        check("alu_valid", bus.valid_ex, 1'b1);
        check("alu_fields", {bus.op_ex, bus.rd_ex, bus.reg_wr_ex, bus.pc_ex}, {AL, 3'd2, 1'b1, 8'd0});
        repeat (4) cycle();

        // load-use: exactly one stall
        fill_nop();
        prog[0] = mk(LD, 3'd3, 3'd1, 3'd0, 8'h00);
        prog[1] = mk(AL, 3'd1, 3'd3, 3'd0, 8'h00);
        do_reset();
        stall_seen = 0;
        repeat (8) cycle();
        check("lu_stalls", stall_seen, 1);
        check("lu_cnt", bus.stall_cnt, 8'd1);

        // load then independent ALU: no stall
        prog[1] = mk(AL, 3'd1, 3'd4, 3'd5, 8'h00);
        do_reset();
        stall_seen = 0;
        repeat (8) cycle();
        check("nolu_stalls", stall_seen, 0);
        check("nolu_cnt", bus.stall_cnt, 8'd0);

        // jump at 5 to 8, squashing 6
        fill_nop();
        prog[5] = mk(JP, 3'd0, 3'd0, 3'd0, 8'd8);
        prog[6] = mk(AL, 3'd1, 3'd1, 3'd1, 8'h66);
        prog[8] = mk(AL, 3'd2, 3'd2, 3'd2, 8'h88);
        do_reset();
        repeat (14) cycle();
        check("jmp_flush_cnt", bus.flush_cnt, 8'd1);

        // stall counter saturation
        for (int i = 0; i < 256; i += 2) begin
            prog[i] = mk(LD, 3'd3, 3'd0, 3'd0, 8'h00);
            prog[i + 1] = mk(AL, 3'd1, 3'd3, 3'd0, 8'h00);
        end
        do_reset();
        repeat (800) cycle();
        check("sat_stall_cnt", bus.stall_cnt, 8'd255);

        // asynchronous reset during a stall
        do_reset();
        begin
            int n = 0;
            while (!model_hz() && n < 10) begin
                cycle();
                n++;
            end
            check("found_stall", model_hz(), 1'b1);
        end
        #3 check("pre_rst_stall", bus.Stall, 1'b1);
        rst = 1'b1;
        #1 check_zero("async_rst");
        fill_nop();
        prog[0] = mk(AL, 3'd3, 3'd3, 3'd3, 8'h01);
        prog[1] = mk(AL, 3'd3, 3'd3, 3'd3, 8'h02);
        do_reset();
        stall_seen = 0;
        repeat (6) cycle();
        check("post_rst_stalls", stall_seen, 0);

        // random programs
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) begin
                int k = $urandom_range(0, 9);
                logic [4:0] op = k < 3 ? LD : k == 3 ? ST : k == 4 ? JP : k == 5 ? 5'd0 : 5'($urandom_range(1, 15));
                prog[i] = mk(op, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                             3'($urandom_range(0, 3)), 8'($urandom));
            end
            do_reset();
            repeat (700) cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
